// File: rtl/audio_dac_serializer_if.sv
// rtl/audio_dac_serializer_if.sv - write port and codec DAC pins of the I2S serializer
interface audio_dac_serializer_if #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 8
);
  logic                          write;
  logic [DATA_WIDTH-1:0]         writedata_left;
  logic [DATA_WIDTH-1:0]         writedata_right;
  logic                          write_ready;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          underflow;
  logic                          AUD_BCLK;
  logic                          AUD_DACLRCK;
  logic                          AUD_DACDAT;

  modport master (
    output write, writedata_left, writedata_right, AUD_BCLK, AUD_DACLRCK,
    input  write_ready, fifo_count, underflow, AUD_DACDAT
  );

  modport slave (
    input  write, writedata_left, writedata_right, AUD_BCLK, AUD_DACLRCK,
    output write_ready, fifo_count, underflow, AUD_DACDAT
  );
endinterface

// File: rtl/audio_dac_serializer.sv
// rtl/audio_dac_serializer.sv - stereo-pair FIFO feeding an I2S DAC shifter in the CLOCK_50 domain
// Build option DAC_UNDERFLOW_REPEAT_EN: an underflow replays the last popped pair instead of silence.
module audio_dac_serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  audio_dac_serializer_if.slave dac_if
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_WIDTH + 2);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] CNT_SAT   = BW'(DATA_WIDTH + 1);
  localparam logic [BW-1:0] CNT_FIRST = BW'(1);

  localparam logic [1:0] ST_SYNC  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  logic bclk_s1_q, bclk_s2_q, bclk_hist_q;
  logic lrck_s1_q, lrck_s2_q, lrck_hist_q;
  logic bclk_fall, lr, unused_lrck_hist;

  logic [2*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q, count_d;
  logic                    push, pop, fifo_empty;

  logic [1:0]            state_q, state_d;
  logic                  lr_q, lr_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic                  dacdat_q, dacdat_d, underflow_q, underflow_d;
`ifdef DAC_UNDERFLOW_REPEAT_EN
  logic [2*DATA_WIDTH-1:0] last_q, last_d;
`endif

  // Both pins see the same synchronizer depth so LRCK is coherent with the detected BCLK fall.
  assign bclk_fall        = bclk_hist_q & ~bclk_s2_q;
  assign lr               = lrck_s2_q;
  assign unused_lrck_hist = lrck_hist_q;

  assign fifo_empty = (count_q == '0);
  assign push       = dac_if.write && (count_q != FULL_CNT);

  assign dac_if.write_ready = (count_q != FULL_CNT);
  assign dac_if.fifo_count  = count_q;
  assign dac_if.underflow   = underflow_q;
  assign dac_if.AUD_DACDAT  = dacdat_q;

  always_comb begin
    state_d     = state_q;
    lr_d        = lr_q;
    bit_cnt_d   = bit_cnt_q;
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    dacdat_d    = dacdat_q;
    underflow_d = 1'b0;
    pop         = 1'b0;
`ifdef DAC_UNDERFLOW_REPEAT_EN
    last_d      = last_q;
`endif
    if (bclk_fall) begin
      lr_d     = lr;
      dacdat_d = 1'b0;
      if (lr_q && !lr) begin
        state_d   = ST_LEFT;
        bit_cnt_d = CNT_FIRST;
        if (fifo_empty) begin
          underflow_d = 1'b1;
`ifdef DAC_UNDERFLOW_REPEAT_EN
          {shift_l_d, shift_r_d} = last_q;
`else
          {shift_l_d, shift_r_d} = '0;
`endif
        end else begin
          pop = 1'b1;
          {shift_l_d, shift_r_d} = mem_q[rd_ptr_q];
`ifdef DAC_UNDERFLOW_REPEAT_EN
          last_d = mem_q[rd_ptr_q];
`endif
        end
      end else if (state_q == ST_LEFT && !lr_q && lr) begin
        state_d   = ST_RIGHT;
        bit_cnt_d = CNT_FIRST;
      end else if (state_q != ST_SYNC && bit_cnt_q != CNT_SAT) begin
        // Slots 1..DATA_WIDTH: shift the active channel out MSB first, then hold 0.
        if (state_q == ST_LEFT) begin
          dacdat_d  = shift_l_q[DATA_WIDTH-1];
          shift_l_d = shift_l_q << 1;
        end else begin
          dacdat_d  = shift_r_q[DATA_WIDTH-1];
          shift_r_d = shift_r_q << 1;
        end
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {dac_if.writedata_left, dac_if.writedata_right};
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      bclk_s1_q   <= 1'b0;
      bclk_s2_q   <= 1'b0;
      bclk_hist_q <= 1'b0;
      lrck_s1_q   <= 1'b0;
      lrck_s2_q   <= 1'b0;
      lrck_hist_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= ST_SYNC;
      lr_q        <= 1'b0;
      bit_cnt_q   <= '0;
      shift_l_q   <= '0;
      shift_r_q   <= '0;
      dacdat_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      bclk_s1_q   <= dac_if.AUD_BCLK;
      bclk_s2_q   <= bclk_s1_q;
      bclk_hist_q <= bclk_s2_q;
      lrck_s1_q   <= dac_if.AUD_DACLRCK;
      lrck_s2_q   <= lrck_s1_q;
      lrck_hist_q <= lrck_s2_q;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q     <= count_d;
      state_q     <= state_d;
      lr_q        <= lr_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_l_q   <= shift_l_d;
      shift_r_q   <= shift_r_d;
      dacdat_q    <= dacdat_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef DAC_UNDERFLOW_REPEAT_EN
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= '0;
    end else begin
      last_q <= last_d;
    end
  end
`endif
endmodule

// File: tb/tb_audio_dac_serializer.sv
// tb/tb_audio_dac_serializer.sv - scoreboard bench for audio_dac_serializer against a slot-level I2S model
module tb_audio_dac_serializer;
  localparam int DW = 24;
  localparam int FD = 8;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  audio_dac_serializer_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) bus ();

  audio_dac_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .dac_if   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference model: pairs queued by writes, channel/slot position derived from LRCK edges.
  logic [2*DW-1:0] model_q [$];
  bit              exp_q [$];
  logic [2*DW-1:0] m_pair, m_last;
  int              m_chan;
  int              m_slot;
  bit              m_prev_lr;
  bit              m_last_exp;
  int              exp_uf = 0;
  int              uf_seen = 0;
  event            fall_ev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    m_pair    = '0;
    m_last    = '0;
    m_chan    = 0;
    m_slot    = 0;
    m_prev_lr = 1'b0;
  endtask

  task automatic model_fall(input bit lr);
    logic [DW-1:0] smp;
    bit e;
    if (m_prev_lr && !lr) begin
      m_chan = 1;
      m_slot = 0;
      if (model_q.size() == 0) begin
        exp_uf++;
`ifdef DAC_UNDERFLOW_REPEAT_EN
        m_pair = m_last;
`else
        m_pair = '0;
`endif
      end else begin
        m_pair = model_q.pop_front();
        m_last = m_pair;
      end
    end else if (m_chan == 1 && !m_prev_lr && lr) begin
      m_chan = 2;
      m_slot = 0;
    end else if (m_chan != 0) begin
      m_slot++;
    end
    m_prev_lr = lr;
    smp = (m_chan == 1) ? m_pair[2*DW-1:DW] : m_pair[DW-1:0];
    if (m_chan == 0 || m_slot == 0 || m_slot > DW) e = 1'b0;
    else e = smp[DW - m_slot];
    m_last_exp = e;
    exp_q.push_back(e);
  endtask

  task automatic write_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    bus.write           = 1'b1;
    bus.writedata_left  = l;
    bus.writedata_right = r;
    if (model_q.size() < FD) model_q.push_back({l, r});
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic write_rand();
    logic [DW-1:0] l, r;
    l = DW'($urandom);
    r = DW'($urandom);
    write_pair(l, r);
  endtask

  // One BCLK period starting at its falling edge; LRCK changes on that same edge.
  task automatic bclk_cycle(input bit lr, input int nwr, input bit sim_wr);
    bus.AUD_BCLK    = 1'b0;
    bus.AUD_DACLRCK = lr;
    model_fall(lr);
    -> fall_ev;
    if (sim_wr) begin
      repeat (2) @(negedge clk);
      write_rand();
      @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
    bus.AUD_BCLK = 1'b1;
    for (int k = 0; k < nwr; k++) write_rand();
    repeat (4 - nwr) @(negedge clk);
  endtask

  task automatic frame(input int half, input int max_wr, input bit sim_wr);
    for (int s = 0; s < 2 * half; s++) begin
      int nwr;
      nwr = (s == half + 4 && max_wr > 0) ? int'($urandom_range(0, max_wr)) : 0;
      bclk_cycle(s >= half, nwr, sim_wr && s == 0);
    end
  endtask

  initial begin
    forever begin
      @(fall_ev);
      repeat (5) @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dacdat_slot: got %b with no expected bit queued", bus.AUD_DACDAT);
      end else begin
        bit e;
        e = exp_q.pop_front();
        if (bus.AUD_DACDAT !== e) begin
          errors++;
          $display("FAIL dacdat_slot: got %b expected %b (chan %0d slot %0d)", bus.AUD_DACDAT, e, m_chan, m_slot);
        end
      end
    end
  end

  always @(negedge clk) if (bus.underflow === 1'b1) uf_seen++;

  initial begin
    #1500us;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    bit sim_done;
    sim_done            = 1'b0;
    reset_n             = 1'b0;
    bus.write           = 1'b0;
    bus.writedata_left  = '0;
    bus.writedata_right = '0;
    bus.AUD_BCLK        = 1'b1;
    bus.AUD_DACLRCK     = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_write_ready", 32'(bus.write_ready), 32'd1);
    check("reset_fifo_count", 32'(bus.fifo_count), 32'd0);
    check("reset_underflow", 32'(bus.underflow), 32'd0);
    check("reset_dacdat", 32'(bus.AUD_DACDAT), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 4; i++) bclk_cycle(1'b1, 0, 1'b0);

    write_pair(24'hA5F00F, 24'h800001);
    check("single_count", 32'(bus.fifo_count), 32'd1);
    frame(32, 0, 1'b0);
    frame(32, 0, 1'b0);
    check("single_underflow", 32'(uf_seen), 32'(exp_uf));

    for (int i = 0; i < FD; i++) write_rand();
    check("fill_count", 32'(bus.fifo_count), 32'(FD));
    check("fill_write_ready", 32'(bus.write_ready), 32'd0);
    write_rand();
    check("full_write_ignored", 32'(bus.fifo_count), 32'(model_q.size()));

    for (int k = 0; k < 10; k++) begin
      bit sim;
      sim = (!sim_done && model_q.size() == 3);
      if (sim) sim_done = 1'b1;
      frame(32, 0, sim);
      check(sim ? "push_pop_count" : "replay_count", 32'(bus.fifo_count), 32'(model_q.size()));
    end
    check("replay_underflow", 32'(uf_seen), 32'(exp_uf));

    for (int f = 0; f < 12; f++) begin
      int half;
      case ($urandom_range(0, 2))
        0:       half = 16;
        1:       half = 24;
        default: half = 32;
      endcase
      frame(half, 3, 1'b0);
      check("random_count", 32'(bus.fifo_count), 32'(model_q.size()));
      check("random_write_ready", 32'(bus.write_ready), 32'(model_q.size() < FD));
    end
    while (model_q.size() > 0) frame(32, 0, 1'b0);
    check("random_underflow", 32'(uf_seen), 32'(exp_uf));

    write_pair(24'hFFFFFF, 24'hFFFFFF);
    for (int s = 0; s < 6; s++) bclk_cycle(1'b0, 0, 1'b0);
    check("pre_reset_dacdat", 32'(bus.AUD_DACDAT), 32'(m_last_exp));
    reset_n = 1'b0;
    #1;
    check("midreset_dacdat", 32'(bus.AUD_DACDAT), 32'd0);
    check("midreset_write_ready", 32'(bus.write_ready), 32'd1);
    check("midreset_fifo_count", 32'(bus.fifo_count), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int s = 6; s < 32; s++) bclk_cycle(1'b0, 0, 1'b0);
    for (int s = 0; s < 32; s++) bclk_cycle(1'b1, (s == 4) ? 1 : 0, 1'b0);
    frame(32, 0, 1'b0);
    frame(32, 0, 1'b0);
    check("post_reset_underflow", 32'(uf_seen), 32'(exp_uf));

    repeat (8) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
